// File: rtl/sdr_port_arbiter_pkg.sv
// rtl/sdr_port_arbiter_pkg.sv - shared FSM state and client index constants for the SDRAM port arbiter
package sdr_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  localparam int CLI_CPU    = 0;
  localparam int CLI_SPRITE = 1;
  localparam int CLI_IOCTL  = 2;

endpackage

// File: rtl/sdr_arb_pick.sv
// rtl/sdr_arb_pick.sv - combinational winner select; SDR_ARB_RR_EN picks round-robin, else fixed priority
module sdr_arb_pick #(
  parameter int NCLI = 3
) (
  input  logic [NCLI-1:0] pending,
  input  logic [1:0]      last,
  output logic [1:0]      win,
  output logic            valid
);

`ifdef SDR_ARB_RR_EN
  // Round-robin: scan from the client after the last winner, wrapping back to it last.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    valid = 1'b0;
    // Walk offsets far-to-near so the nearest pending client is the final assignment.
    for (int k = NCLI; k >= 1; k--) begin
      idx = (int'(last) + k) % NCLI;
      if (|(pending & (NCLI'(1) << idx))) begin
        win   = 2'(idx);
        valid = 1'b1;
      end
    end
  end
`else
  // Fixed priority has no memory of the previous winner.
  logic unused_last;
  assign unused_last = ^last;

  // Fixed priority: the lowest pending index wins (CPU, then sprite, then ioctl).
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int i = NCLI - 1; i >= 0; i--) begin
      if (|(pending & (NCLI'(1) << i))) begin
        win   = 2'(i);
        valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sdr_port_arbiter.sv
// rtl/sdr_port_arbiter.sv - toggle-handshake SDRAM port arbiter; policy selected by SDR_ARB_RR_EN
module sdr_port_arbiter #(
  parameter int NCLI = 3,
  parameter int AW   = 24
) (
  input  logic                 CLK_32M,
  input  logic                 reset,
  input  logic [NCLI-1:0]      c_req,
  output logic [NCLI-1:0]      c_ack,
  input  logic [NCLI*AW-1:0]   c_addr,
  input  logic [NCLI*16-1:0]   c_din,
  input  logic [NCLI*2-1:0]    c_wr_sel,
  output logic [15:0]          c_dout,
  output logic [AW-1:0]        sdr_addr,
  output logic [15:0]          sdr_din,
  output logic [1:0]           sdr_wr_sel,
  output logic                 sdr_req,
  input  logic                 sdr_ack,
  input  logic [15:0]          sdr_dout,
  output logic [1:0]           grant,
  output logic                 busy
);
  import sdr_port_arbiter_pkg::*;

  arb_state_t      state;
  logic [1:0]      last_grant;
  logic [NCLI-1:0] pending;
  logic [1:0]      win;
  logic            win_valid;
  logic [AW-1:0]   win_addr;
  logic [15:0]     win_din;
  logic [1:0]      win_wr_sel;

  // A client is pending while its toggle request differs from its acknowledge.
  assign pending = c_req ^ c_ack;

  sdr_arb_pick #(
    .NCLI (NCLI)
  ) u_pick (
    .pending (pending),
    .last    (last_grant),
    .win     (win),
    .valid   (win_valid)
  );

  // Route the winning client's address, data and byte enables toward the grant edge.
  always_comb begin
    win_addr   = '0;
    win_din    = '0;
    win_wr_sel = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (win == 2'(i)) begin
        win_addr   = c_addr[i*AW +: AW];
        win_din    = c_din[i*16 +: 16];
        win_wr_sel = c_wr_sel[i*2 +: 2];
      end
    end
  end

  // IDLE/WAIT controller: capture the winner on grant, return data and ack on SDRAM completion.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state      <= ST_IDLE;
      sdr_req    <= 1'b0;
      c_ack      <= '0;
      c_dout     <= '0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      sdr_wr_sel <= '0;
      grant      <= 2'(CLI_CPU);
      busy       <= 1'b0;
      last_grant <= 2'(NCLI - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            sdr_addr   <= win_addr;
            sdr_din    <= win_din;
            sdr_wr_sel <= win_wr_sel;
            sdr_req    <= ~sdr_req;
            grant      <= win;
            last_grant <= win;
            busy       <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdr_ack == sdr_req) begin
            c_dout <= sdr_dout;
            // Copying the live request (not a flip) absorbs a re-toggle made mid-transfer.
            for (int i = 0; i < NCLI; i++) begin
              if (grant == 2'(i)) begin
                c_ack[i] <= c_req[i];
              end
            end
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// tb/tb_sdr_port_arbiter.sv - scoreboard bench for sdr_port_arbiter with a behavioural SDRAM responder
module tb_sdr_port_arbiter;
  import sdr_port_arbiter_pkg::*;

  localparam int NCLI = 3;
  localparam int AW   = 24;
  localparam int NVEC = 6;

  logic                CLK_32M = 1'b0;
  logic                reset;
  logic [NCLI-1:0]     c_req;
  logic [NCLI-1:0]     c_ack;
  logic [NCLI*AW-1:0]  c_addr;
  logic [NCLI*16-1:0]  c_din;
  logic [NCLI*2-1:0]   c_wr_sel;
  logic [15:0]         c_dout;
  logic [AW-1:0]       sdr_addr;
  logic [15:0]         sdr_din;
  logic [1:0]          sdr_wr_sel;
  logic                sdr_req;
  logic                sdr_ack;
  logic [15:0]         sdr_dout;
  logic [1:0]          grant;
  logic                busy;

  typedef struct {
    int            cli;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [1:0]    ws;
    logic [15:0]   dout;
  } xfer_t;

  typedef struct {
    int            cli;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [1:0]    ws;
    int            lat;
    logic [15:0]   exp_dout;
  } vec_t;

  xfer_t exp_q[$];
  xfer_t done_q[$];
  int    tests = 0;
  int    fails = 0;
  int    sdram_lat = 3;

  sdr_port_arbiter #(.NCLI(NCLI), .AW(AW)) dut (
    .CLK_32M    (CLK_32M),
    .reset      (reset),
    .c_req      (c_req),
    .c_ack      (c_ack),
    .c_addr     (c_addr),
    .c_din      (c_din),
    .c_wr_sel   (c_wr_sel),
    .c_dout     (c_dout),
    .sdr_addr   (sdr_addr),
    .sdr_din    (sdr_din),
    .sdr_wr_sel (sdr_wr_sel),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_dout   (sdr_dout),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 CLK_32M = ~CLK_32M;

  function automatic logic [15:0] sdram_word(input logic [AW-1:0] a);
    if (a == 24'h012345) return 16'hBEEF;
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_client(input int cli, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] w);
    c_addr[cli*AW +: AW] = a;
    c_din[cli*16 +: 16]  = d;
    c_wr_sel[cli*2 +: 2] = w;
  endtask

  task automatic push_exp(input int cli, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] w,
                          input logic [15:0] dout);
    xfer_t e;
    e.cli = cli; e.addr = a; e.din = d; e.ws = w; e.dout = dout;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge CLK_32M); #1;
      if (exp_q.size() == 0 && done_q.size() == 0 && !busy && c_req == c_ack) break;
    end
    check({tag, "_completes"}, 32'(k < budget), 1);
  endtask

  task automatic do_reset();
    @(negedge CLK_32M);
    reset = 1'b1;
    c_req = '0;
    @(negedge CLK_32M);
    @(negedge CLK_32M);
    reset = 1'b0;
    @(negedge CLK_32M);
  endtask

  // SDRAM responder: acknowledges a toggle after sdram_lat falling edges.
  initial begin
    int cnt;
    cnt      = 0;
    sdr_ack  = 1'b0;
    sdr_dout = '0;
    forever begin
      @(negedge CLK_32M);
      if (reset) begin
        sdr_ack = 1'b0;
        cnt     = 0;
      end else if (sdr_req !== sdr_ack) begin
        cnt++;
        if (cnt >= sdram_lat) begin
          sdr_dout = sdram_word(sdr_addr);
          sdr_ack  = sdr_req;
          cnt      = 0;
        end
      end
    end
  end

  // Scoreboard: pop on every sdr_req toggle, retire on every c_ack toggle.
  initial begin
    xfer_t           e;
    logic            prev_req;
    logic [NCLI-1:0] prev_ack;
    prev_req = 1'b0;
    prev_ack = '0;
    forever begin
      @(posedge CLK_32M); #1;
      if (reset) begin
        exp_q.delete();
        done_q.delete();
      end else begin
        if (sdr_req !== prev_req) begin
          check("grant_was_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant", grant, e.cli);
            check("sdr_addr", sdr_addr, e.addr);
            check("sdr_din", sdr_din, e.din);
            check("sdr_wr_sel", sdr_wr_sel, e.ws);
            check("busy_on_grant", busy, 1);
            done_q.push_back(e);
          end
        end
        if (c_ack !== prev_ack) begin
          check("ack_was_expected", 32'(done_q.size() > 0), 1);
          if (done_q.size() > 0) begin
            e = done_q.pop_front();
            check("ack_client", c_ack ^ prev_ack, 32'(NCLI'(1) << e.cli));
            check("c_dout", c_dout, e.dout);
            check("busy_after_ack", busy, 0);
          end
        end
      end
      prev_req = sdr_req;
      prev_ack = c_ack;
    end
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[NVEC];
    logic          req_before;
    logic          exp_req;
    int            k;
    int            order[6];
    int            left[NCLI];
    logic [AW-1:0] rr_addr[NCLI];

    vecs[0] = '{CLI_SPRITE, 24'h040000, 16'hA55A, 2'b01, 3, 16'hC3A5};
    vecs[1] = '{CLI_IOCTL,  24'hFFFFFF, 16'hFFFF, 2'b11, 1, 16'h3C5A};
    vecs[2] = '{CLI_CPU,    24'h000001, 16'h1234, 2'b10, 2, 16'hC3A4};
    vecs[3] = '{CLI_IOCTL,  24'h800ABC, 16'h0000, 2'b00, 4, 16'hC919};
    vecs[4] = '{CLI_SPRITE, 24'h00FFFF, 16'h5555, 2'b10, 1, 16'h3C5A};
    vecs[5] = '{CLI_CPU,    24'h012345, 16'h0000, 2'b00, 6, 16'hBEEF};

    reset    = 1'b1;
    c_req    = '0;
    c_addr   = '0;
    c_din    = '0;
    c_wr_sel = '0;

    // A request held during reset must not be granted.
    repeat (2) @(negedge CLK_32M);
    c_req = 3'b010;
    @(posedge CLK_32M); #1;
    check("rst_no_grant_busy", busy, 0);
    check("rst_no_grant_req", sdr_req, 0);
    @(negedge CLK_32M);
    c_req = '0;
    @(posedge CLK_32M); #1;
    check("rst_c_ack", c_ack, 0);
    check("rst_grant", grant, 0);
    check("rst_sdr_addr", sdr_addr, 0);
    check("rst_sdr_din", sdr_din, 0);
    check("rst_sdr_wr_sel", sdr_wr_sel, 0);
    check("rst_c_dout", c_dout, 0);
    @(negedge CLK_32M);
    reset = 1'b0;
    @(negedge CLK_32M);

    // Single CPU read with latency checks and a mid-transfer input change.
    sdram_lat = 5;
    set_client(CLI_CPU, 24'h012345, 16'h0000, 2'b00);
    push_exp(CLI_CPU, 24'h012345, 16'h0000, 2'b00, 16'hBEEF);
    req_before = sdr_req;
    exp_req    = ~req_before;
    c_req ^= 3'b001;
    @(posedge CLK_32M); #1;
    check("cpu_req_next_cycle", sdr_req, exp_req);
    check("cpu_sdr_addr", sdr_addr, 24'h012345);
    @(negedge CLK_32M);
    set_client(CLI_CPU, 24'hFFFFFF, 16'h1111, 2'b11);
    repeat (2) @(posedge CLK_32M);
    #1;
    check("wait_addr_hold", sdr_addr, 24'h012345);
    check("wait_din_hold", sdr_din, 16'h0000);
    check("wait_wr_sel_hold", sdr_wr_sel, 2'b00);
    for (k = 0; k < 20; k++) begin
      @(negedge CLK_32M); #1;
      if (sdr_ack == sdr_req) break;
    end
    check("cpu_sdram_acked", 32'(k < 20), 1);
    check("cpu_still_pending", c_ack[0] ^ c_req[0], 1);
    @(posedge CLK_32M); #1;
    check("cpu_ack_next_cycle", c_ack[0] ^ c_req[0], 0);
    check("cpu_c_dout", c_dout, 16'hBEEF);
    wait_idle("cpu_read", 20);

    // Table of single transfers across clients, directions and latencies.
    for (int v = 0; v < NVEC; v++) begin
      @(negedge CLK_32M);
      sdram_lat = vecs[v].lat;
      set_client(vecs[v].cli, vecs[v].addr, vecs[v].din, vecs[v].ws);
      push_exp(vecs[v].cli, vecs[v].addr, vecs[v].din, vecs[v].ws, vecs[v].exp_dout);
      c_req ^= NCLI'(1) << vecs[v].cli;
      wait_idle($sformatf("vec%0d", v), 40);
    end

    // All three clients request on the same edge.
    @(negedge CLK_32M);
    sdram_lat = 3;
    set_client(CLI_CPU,    24'h0A0A0A, 16'h0000, 2'b00);
    set_client(CLI_SPRITE, 24'h0B0B0B, 16'hCAFE, 2'b11);
    set_client(CLI_IOCTL,  24'h0C0C0C, 16'h0F0F, 2'b10);
    push_exp(CLI_CPU,    24'h0A0A0A, 16'h0000, 2'b00, sdram_word(24'h0A0A0A));
    push_exp(CLI_SPRITE, 24'h0B0B0B, 16'hCAFE, 2'b11, sdram_word(24'h0B0B0B));
    push_exp(CLI_IOCTL,  24'h0C0C0C, 16'h0F0F, 2'b10, sdram_word(24'h0C0C0C));
    c_req ^= 3'b111;
    wait_idle("simultaneous", 60);

    // Reset two cycles into WAIT abandons the transfer.
    @(negedge CLK_32M);
    sdram_lat = 30;
    set_client(CLI_SPRITE, 24'h00AAAA, 16'h7777, 2'b11);
    push_exp(CLI_SPRITE, 24'h00AAAA, 16'h7777, 2'b11, sdram_word(24'h00AAAA));
    c_req ^= 3'b010;
    @(posedge CLK_32M); #1;
    check("midrst_in_wait", busy, 1);
    @(negedge CLK_32M);
    @(negedge CLK_32M);
    reset = 1'b1;
    c_req = '0;
    @(posedge CLK_32M); #1;
    check("midrst_sdr_req", sdr_req, 0);
    check("midrst_c_ack", c_ack, 0);
    check("midrst_busy", busy, 0);
    @(negedge CLK_32M);
    reset = 1'b0;
    @(negedge CLK_32M);
    sdram_lat = 2;
    set_client(CLI_IOCTL, 24'h123456, 16'h4242, 2'b11);
    push_exp(CLI_IOCTL, 24'h123456, 16'h4242, 2'b11, sdram_word(24'h123456));
    c_req ^= 3'b100;
    wait_idle("post_reset", 30);

    // Every client re-requests once, right after its own acknowledge.
    do_reset();
    sdram_lat  = 2;
    rr_addr[0] = 24'h100111;
    rr_addr[1] = 24'h200222;
    rr_addr[2] = 24'h300333;
    for (int i = 0; i < NCLI; i++) begin
      set_client(i, rr_addr[i], 16'(i + 16'h0100), 2'(i));
      left[i] = 2;
    end
`ifdef SDR_ARB_RR_EN
    order = '{0, 1, 2, 0, 1, 2};
`else
    order = '{0, 0, 1, 1, 2, 2};
`endif
    for (int j = 0; j < 6; j++) begin
      push_exp(order[j], rr_addr[order[j]], 16'(order[j] + 16'h0100), 2'(order[j]),
               sdram_word(rr_addr[order[j]]));
    end
    for (k = 0; k < 200; k++) begin
      if (left[0] == 0 && left[1] == 0 && left[2] == 0) break;
      @(negedge CLK_32M);
      for (int i = 0; i < NCLI; i++) begin
        if (left[i] > 0 && c_req[i] == c_ack[i]) begin
          c_req ^= NCLI'(1) << i;
          left[i]--;
        end
      end
    end
    check("rereq_all_issued", 32'(k < 200), 1);
    wait_idle("rereq", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
